// File: rtl/text_write_ctrl.sv
// Write-side controller for the character-cell text buffer: turns a byte stream
// into single-cell RAM writes and sweeps full-screen / single-row clears.
//   state     | meaning
//   CLEAR_ALL | zeroing every cell row-major, one per cycle
//   IDLE      | accepting bytes
//   CLEAR_ROW | zeroing the cursor row, one cell per cycle
module text_write_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 32,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [RW-1:0]         ram_row,
    output logic [CW-1:0]         ram_col,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [RW-1:0]         cur_row,
    output logic [CW-1:0]         cur_col,
    output logic                  busy
);

    localparam int CELLS = ROWS * COLS;
    localparam int NW    = $clog2(CELLS + 1);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [NW-1:0] N_ALL    = NW'(CELLS);
    localparam logic [NW-1:0] N_ROW    = NW'(COLS);

    localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_FF    = DATA_WIDTH'(8'h0C);
    localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         cur_row_q, cur_row_d;
    logic [CW-1:0]         cur_col_q, cur_col_d;
    logic [RW-1:0]         sw_row_q, sw_row_d;
    logic [CW-1:0]         sw_col_q, sw_col_d;
    logic [NW-1:0]         sw_left_q, sw_left_d;
    logic                  ram_we_q, ram_we_d;
    logic [RW-1:0]         ram_row_q, ram_row_d;
    logic [CW-1:0]         ram_col_q, ram_col_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

    logic [RW-1:0] row_inc;
    logic          printable;

    assign row_inc   = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + 1'b1;
    assign printable = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ALL;
            cur_row_q <= '0;
            cur_col_q <= '0;
            sw_row_q  <= '0;
            sw_col_q  <= '0;
            sw_left_q <= N_ALL;
            ram_we_q  <= 1'b0;
            ram_row_q <= '0;
            ram_col_q <= '0;
            ram_din_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            sw_row_q  <= sw_row_d;
            sw_col_q  <= sw_col_d;
            sw_left_q <= sw_left_d;
            ram_we_q  <= ram_we_d;
            ram_row_q <= ram_row_d;
            ram_col_q <= ram_col_d;
            ram_din_q <= ram_din_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        sw_row_d  = sw_row_q;
        sw_col_d  = sw_col_q;
        sw_left_d = sw_left_q;
        ram_we_d  = 1'b0;
        ram_row_d = ram_row_q;
        ram_col_d = ram_col_q;
        ram_din_d = ram_din_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        ram_we_d  = 1'b1;
                        ram_row_d = cur_row_q;
                        ram_col_d = cur_col_q;
                        ram_din_d = in_data;
                        if (cur_col_q != LAST_COL) begin
                            cur_col_d = cur_col_q + 1'b1;
                        end else begin
                            cur_col_d = '0;
                            cur_row_d = row_inc;
                            sw_row_d  = row_inc;
                            sw_col_d  = '0;
                            sw_left_d = N_ROW;
                            state_d   = CLEAR_ROW;
                        end
                    end else if (in_data == CH_CR) begin
                        cur_col_d = '0;
                    end else if (in_data == CH_LF) begin
                        cur_col_d = '0;
                        cur_row_d = row_inc;
                        sw_row_d  = row_inc;
                        sw_col_d  = '0;
                        sw_left_d = N_ROW;
                        state_d   = CLEAR_ROW;
                    end else if (in_data == CH_BS) begin
                        // Backspace erases the cell it moves onto; no-op at home.
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - 1'b1;
                            ram_we_d  = 1'b1;
                            ram_row_d = cur_row_q;
                            ram_col_d = cur_col_q - 1'b1;
                            ram_din_d = '0;
                        end else if (cur_row_q != '0) begin
                            cur_row_d = cur_row_q - 1'b1;
                            cur_col_d = LAST_COL;
                            ram_we_d  = 1'b1;
                            ram_row_d = cur_row_q - 1'b1;
                            ram_col_d = LAST_COL;
                            ram_din_d = '0;
                        end
                    end else if (in_data == CH_FF) begin
                        cur_row_d = '0;
                        cur_col_d = '0;
                        sw_row_d  = '0;
                        sw_col_d  = '0;
                        sw_left_d = N_ALL;
                        state_d   = CLEAR_ALL;
                    end
                end
            end
            default: begin
                // Sweep runs until the down-counter hits zero; that extra cycle
                // keeps in_ready low while the final clear write is on the bus.
                if (sw_left_q != '0) begin
                    ram_we_d  = 1'b1;
                    ram_row_d = sw_row_q;
                    ram_col_d = sw_col_q;
                    ram_din_d = '0;
                    sw_left_d = sw_left_q - 1'b1;
                    if (sw_col_q == LAST_COL) begin
                        sw_col_d = '0;
                        sw_row_d = sw_row_q + 1'b1;
                    end else begin
                        sw_col_d = sw_col_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign ram_we   = ram_we_q;
    assign ram_row  = ram_row_q;
    assign ram_col  = ram_col_q;
    assign ram_din  = ram_din_q;
    assign cur_row  = cur_row_q;
    assign cur_col  = cur_col_q;

endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Write-side controller for the character-cell text buffer (ROWS×COLS dual-port RAM feeding the display). Accepts a byte stream from the receive path over a valid/ready handshake and tracks a text cursor. Translates printable characters and control codes into single-cell RAM writes. Sequences full-screen and single-row clears one cell per clock, so the display read port is never starved.

## Interface
Parameters:
- DATA_WIDTH, 8, character width
- ROWS, 4, text rows
- COLS, 32, text columns (RW = $clog2(ROWS), CW = $clog2(COLS); both ≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  byte offered
- in_data  in  DATA_WIDTH  byte
- in_ready  out  1  controller can accept this cycle
- ram_we  out  1  RAM write enable
- ram_row  out  RW  RAM write row
- ram_col  out  CW  RAM write column
- ram_din  out  DATA_WIDTH  RAM write data
- cur_row  out  RW  cursor row
- cur_col  out  CW  cursor column
- busy  out  1  clear sequence in progress

## Operation
- States: CLEAR_ALL, IDLE, CLEAR_ROW.
- Accept = in_valid && in_ready. in_ready = (state==IDLE). All RAM outputs are registered.
- Byte handling in IDLE, at accept, with cursor (r,c):
  - 0x20–0x7E:
    - Write byte at (r,c).
    - If c<COLS-1: c+1.
    - Else c=0, r=(r+1) mod ROWS, then CLEAR_ROW on the new r.
  - 0x0D (CR): c=0. No write.
  - 0x0A (LF): c=0, r=(r+1) mod ROWS, then CLEAR_ROW on the new r. No other write.
  - 0x08 (BS):
    - If c>0: c-1, then write 0x00 at (r,c-1).
    - Else if r>0: r-1, c=COLS-1, then write 0x00 there.
    - At (0,0): no-op, byte still consumed.
  - 0x0C (FF): cursor to (0,0), enter CLEAR_ALL.
  - All other bytes: consumed and dropped. No write, cursor unchanged.
- CLEAR_ALL:
  - Writes 0x00 to every cell in row-major order (0,0),(0,1)…(ROWS-1,COLS-1), one cell per cycle, ROWS·COLS cycles.
  - Then goes to IDLE.
- CLEAR_ROW:
  - Writes 0x00 to (r,0)…(r,COLS-1), one per cycle, COLS cycles.
  - Then goes to IDLE.
- busy=1 in CLEAR_ALL and CLEAR_ROW, 0 in IDLE.
- Wrap past the last row returns to row 0, which is cleared. There is no scrolling.

## Timing
- reset asserted:
  - Next-edge values: ram_we=0, ram_din=0, ram_row=0, ram_col=0, cur_row=0, cur_col=0, in_ready=0, busy=1.
  - State becomes CLEAR_ALL with sweep index 0.
  - Reset held for multiple cycles keeps the sweep at index 0 with ram_we=0.
- First cycle after reset deasserts: ram_we=1 at (0,0).
  - The ROWS·COLS-th write lands in cycle ROWS·COLS.
  - in_ready=1 in the following cycle (128 write cycles at defaults).
- Byte accepted at edge N: its write (if any) has ram_we=1 in the cycle after edge N, with the address of the pre-update cursor. The BS write uses the decremented address.
  - cur_row/cur_col show the updated cursor in the same cycle.
- Throughput: one byte per cycle while in_ready stays high.
- A byte triggering CLEAR_ROW or CLEAR_ALL:
  - in_ready drops the cycle after accept.
  - The printable write (if any) occupies the accept+1 cycle.
  - The first clear write follows on the next cycle; clear writes are consecutive.
- Simultaneous:
  - reset wins over in_valid; the byte is not consumed.
  - in_valid in a non-IDLE state is ignored; the source must hold the byte.
- reset during CLEAR_ALL or CLEAR_ROW abandons that sweep, restarts the full clear from (0,0) and zeros the cursor.
- ram_we is never asserted for dropped bytes, CR, or BS at (0,0).

## Test plan
- Reset for 1 cycle, release:
  - 128 consecutive cycles of ram_we=1, din=0, addresses (0,0)…(3,31).
  - in_ready=1 on cycle 129; busy falls with it.
- Send "AB" back-to-back:
  - Writes 0x41@(0,0), then 0x42@(0,1) on consecutive cycles.
  - Cursor ends at (0,2).
  - in_ready stays high throughout.
- Send 32× 0x41 from (0,0):
  - The last write is at (0,31).
  - Cursor moves to (1,0) and 32 clear writes follow on row 1.
  - in_ready stays low for the 33 cycles after the 32nd accept (1 char write + 32 clears), then returns high.
- Send CR at (1,5):
  - Cursor moves to (1,0), no write.
- From (1,0), send BS:
  - 0x00 written at (0,31); cursor moves to (0,31).
- From (2,7):
  - Send LF: cursor (3,0), row 3 cleared.
  - Then send 0x1B: dropped, no write.
  - Then send LF again: cursor (0,0), row 0 cleared.
- Send 0x0C mid-text, then assert reset on the 10th clear cycle:
  - The sweep restarts at (0,0).
  - A full 128-write clear completes.
  - Cursor reads (0,0).
